// File: rtl/cpu_control_if.sv
// cpu_control_if -- bundle of the Mini-CPU sequencer's bus signals.
//   master : the sequencer (cpu_control). Receives power/send/instr from the
//            front panel and v1RAM/v2RAM/read/stored from the RAM bank.
//            Drives stateCPU, opcode, addr1-3 and valorGuardarRAM towards the
//            RAM bank, and disp_val/disp_valid/err towards the display.
//   slave  : the environment (RAM bank, front panel, display).
// clk and rst are not part of the bundle; they stay plain module ports.
interface cpu_control_if;
  logic        power;
  logic        send;
  logic [15:0] instr;
  logic [15:0] v1RAM;
  logic [15:0] v2RAM;
  logic        read;
  logic        stored;
  logic [2:0]  stateCPU;
  logic [2:0]  opcode;
  logic [3:0]  addr1;
  logic [3:0]  addr2;
  logic [3:0]  addr3;
  logic [15:0] valorGuardarRAM;
  logic [15:0] disp_val;
  logic        disp_valid;
  logic        err;

  modport master (
    input  power, send, instr, v1RAM, v2RAM, read, stored,
    output stateCPU, opcode, addr1, addr2, addr3,
           valorGuardarRAM, disp_val, disp_valid, err
  );

  modport slave (
    output power, send, instr, v1RAM, v2RAM, read, stored,
    input  stateCPU, opcode, addr1, addr2, addr3,
           valorGuardarRAM, disp_val, disp_valid, err
  );
endinterface

// File: rtl/cpu_control.sv
// cpu_control -- top-level sequencer of the Mini-CPU.
// Walks OFF -> FETCH -> DECODE -> READ -> CALC -> SHOW -> STORE -> FETCH,
// latches the instruction word, runs the single-cycle ALU and holds the
// result/display register.
// Ports:
//   clk  : system clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : cpu_control_if.master (front panel, RAM bank handshake, display)
// Parameters:
//   SHOW_CYCLES : clocks disp_valid stays high in SHOW (>= 1)
//   WDOG_CYCLES : READ/STORE handshake timeout (watchdog builds only)
// Build option:
//   CPU_CTRL_WDOG_EN : when defined, a handshake watchdog aborts a stuck
//   READ/STORE back to FETCH and sets the sticky err flag; otherwise err = 0.
module cpu_control #(
  parameter int SHOW_CYCLES = 4,
  parameter int WDOG_CYCLES = 15
) (
  input logic          clk,
  input logic          rst,
  cpu_control_if.master bus
);

  typedef enum logic [2:0] {
    S_OFF    = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_READ   = 3'b011,
    S_CALC   = 3'b100,
    S_SHOW   = 3'b101,
    S_STORE  = 3'b110
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;

  localparam int SHOW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);

  state_t             state_reg;
  logic [15:0]        instr_reg;
  logic [15:0]        result_reg;
  logic [15:0]        disp_val_reg;
  logic               disp_valid_reg;
  logic [SHOW_W-1:0]  show_cnt_reg;

  // Immediates come straight from the latched word, so they are captured on
  // the same edge as opcode/addresses.
  logic [15:0] imm9;
  logic [15:0] imm5;
  logic [15:0] alu_result;

  assign imm9 = {{7{instr_reg[8]}}, instr_reg[8:0]};
  assign imm5 = {{11{instr_reg[4]}}, instr_reg[4:0]};

  // 16-bit operands in a 16-bit context: every result wraps modulo 2^16,
  // and the MUL product is its low half (identical for signed/unsigned).
  always_comb begin
    alu_result = 16'h0000;
    case (instr_reg[15:13])
      OP_LOAD:  alu_result = imm9;
      OP_ADD:   alu_result = bus.v1RAM + bus.v2RAM;
      OP_ADDI:  alu_result = bus.v1RAM + imm5;
      OP_SUB:   alu_result = bus.v1RAM - bus.v2RAM;
      OP_SUBI:  alu_result = bus.v1RAM - imm5;
      OP_MUL:   alu_result = bus.v1RAM * imm5;
      OP_CLEAR: alu_result = 16'h0000;
      default:  alu_result = bus.v1RAM;   // DISPLAY
    endcase
  end

`ifdef CPU_CTRL_WDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              err_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_OFF;
      instr_reg      <= 16'h0000;
      result_reg     <= 16'h0000;
      disp_val_reg   <= 16'h0000;
      disp_valid_reg <= 1'b0;
      show_cnt_reg   <= '0;
`ifdef CPU_CTRL_WDOG_EN
      wdog_cnt_reg   <= '0;
      err_reg        <= 1'b0;
`endif
    end else if (!bus.power) begin
      // Power loss beats every other transition; results are retained.
      state_reg      <= S_OFF;
      disp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_OFF: state_reg <= S_FETCH;
        S_FETCH: begin
          if (bus.send) begin
            instr_reg <= bus.instr;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_reg <= S_READ;
`ifdef CPU_CTRL_WDOG_EN
          wdog_cnt_reg <= '0;
`endif
        end
        S_READ: begin
`ifdef CPU_CTRL_WDOG_EN
          if (bus.read) begin
            state_reg <= S_CALC;
          end else if (wdog_cnt_reg == WDOG_LAST) begin
            // Timed-out read skips CALC/SHOW/STORE: no write-back happens.
            err_reg   <= 1'b1;
            state_reg <= S_FETCH;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
          end
`else
          if (bus.read) state_reg <= S_CALC;
`endif
        end
        S_CALC: begin
          result_reg     <= alu_result;
          disp_val_reg   <= alu_result;
          disp_valid_reg <= 1'b1;
          show_cnt_reg   <= '0;
          state_reg      <= S_SHOW;
        end
        S_SHOW: begin
          if (show_cnt_reg == SHOW_LAST) begin
            disp_valid_reg <= 1'b0;
            state_reg      <= S_STORE;
`ifdef CPU_CTRL_WDOG_EN
            wdog_cnt_reg   <= '0;
`endif
          end else begin
            show_cnt_reg <= show_cnt_reg + SHOW_W'(1);
          end
        end
        S_STORE: begin
`ifdef CPU_CTRL_WDOG_EN
          if (bus.stored) begin
            state_reg <= S_FETCH;
          end else if (wdog_cnt_reg == WDOG_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= S_FETCH;
          end else begin
            wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
          end
`else
          if (bus.stored) state_reg <= S_FETCH;
`endif
        end
        default: state_reg <= S_OFF;
      endcase
    end
  end

  assign bus.stateCPU        = state_reg;
  assign bus.opcode          = instr_reg[15:13];
  assign bus.addr1           = instr_reg[12:9];
  assign bus.addr2           = instr_reg[8:5];
  assign bus.addr3           = instr_reg[4:1];
  assign bus.valorGuardarRAM = result_reg;
  assign bus.disp_val        = disp_val_reg;
  assign bus.disp_valid      = disp_valid_reg;
`ifdef CPU_CTRL_WDOG_EN
  assign bus.err             = err_reg;
`else
  assign bus.err             = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;
  localparam int SHOW_CYCLES = 4;
  localparam int WDOG_CYCLES = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_control_if bus ();

  cpu_control #(.SHOW_CYCLES(SHOW_CYCLES), .WDOG_CYCLES(WDOG_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem[16];
  bit ack_en = 1'b1;
  bit rd_seen = 1'b0;
  bit st_seen = 1'b0;

  // RAM bank model: read/stored rise on the second cycle of READ/STORE.
  always @(negedge clk) begin
    if (bus.stateCPU == 3'b011) begin
      bus.read = ack_en && rd_seen;
      rd_seen  = 1'b1;
    end else begin
      bus.read = 1'b0;
      rd_seen  = 1'b0;
    end
    if (bus.stateCPU == 3'b110) begin
      bus.stored = ack_en && st_seen;
      st_seen    = 1'b1;
    end else begin
      bus.stored = 1'b0;
      st_seen    = 1'b0;
    end
    bus.v1RAM = mem[bus.addr1];
    bus.v2RAM = mem[bus.addr2];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int cyc = 0;
    while (bus.stateCPU !== target && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, {29'd0, bus.stateCPU}, {29'd0, target});
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [15:0] exp, input bit inject);
    int cyc;
    int show_hi;
    logic [15:0] got;
    wait_state(3'b001, 20, "fetch_wait");
    exp_q.push_back(exp);
    bus.instr = ins;
    bus.send  = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    check("decode_state", {29'd0, bus.stateCPU}, 32'd2);
    check("opcode", {29'd0, bus.opcode}, {29'd0, ins[15:13]});
    check("addr1", {28'd0, bus.addr1}, {28'd0, ins[12:9]});
    check("addr2", {28'd0, bus.addr2}, {28'd0, ins[8:5]});
    check("addr3", {28'd0, bus.addr3}, {28'd0, ins[4:1]});
    @(negedge clk);
    check("read_state", {29'd0, bus.stateCPU}, 32'd3);
    cyc = 0;
    while (bus.stateCPU === 3'b011 && cyc < 20) begin
      if (inject && cyc == 0) begin
        bus.send  = 1'b1;
        bus.instr = 16'hFFFF;
      end else begin
        bus.send = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    bus.send = 1'b0;
    check("read_cycles", cyc, 32'd2);
    check("calc_state", {29'd0, bus.stateCPU}, 32'd4);
    @(negedge clk);
    check("show_state", {29'd0, bus.stateCPU}, 32'd5);
    check("sb_size", exp_q.size(), 32'd1);
    got = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check("result", {16'd0, bus.valorGuardarRAM}, {16'd0, got});
    check("disp_val", {16'd0, bus.disp_val}, {16'd0, got});
    cyc = 0;
    show_hi = 0;
    while (bus.stateCPU === 3'b101 && cyc < 20) begin
      if (bus.disp_valid === 1'b1) show_hi++;
      if (inject && cyc == 1) begin
        bus.send  = 1'b1;
        bus.instr = 16'hDEAD;
      end else begin
        bus.send = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    bus.send = 1'b0;
    check("show_cycles", cyc, SHOW_CYCLES);
    check("show_valid", show_hi, SHOW_CYCLES);
    check("store_state", {29'd0, bus.stateCPU}, 32'd6);
    check("dv_low_store", {31'd0, bus.disp_valid}, 32'd0);
    wait_state(3'b001, 20, "store_to_fetch");
    check("opcode_hold", {29'd0, bus.opcode}, {29'd0, ins[15:13]});
    check("addr1_hold", {28'd0, bus.addr1}, {28'd0, ins[12:9]});
    check("disp_hold", {16'd0, bus.disp_val}, {16'd0, got});
    $display("[TB] instr=%h result=%h read_ok show=%0d", ins, bus.valorGuardarRAM, show_hi);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {29'd0, bus.stateCPU}, 32'd0);
    check({tag, "_opaddr"}, {17'd0, bus.opcode, bus.addr1, bus.addr2, bus.addr3}, 32'd0);
    check({tag, "_result"}, {16'd0, bus.valorGuardarRAM}, 32'd0);
    check({tag, "_disp"}, {15'd0, bus.disp_valid, bus.disp_val}, 32'd0);
    check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[1] = 16'h7FFF;
    mem[2] = 16'h0001;
    mem[5] = 16'h1234;
    mem[6] = 16'h0002;
    bus.power  = 1'b1;
    bus.send   = 1'b0;
    bus.instr  = 16'h0000;
    bus.v1RAM  = 16'h0000;
    bus.v2RAM  = 16'h0000;
    bus.read   = 1'b0;
    bus.stored = 1'b0;

    // Reset with power already on.
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("first_after_rst", {29'd0, bus.stateCPU}, 32'd1);

    // Directed ALU instructions (expected values computed by hand).
    run_instr(16'h07FB, 16'hFFFB, 1'b0);   // LOAD imm9=-5
    run_instr(16'h2248, 16'h8000, 1'b0);   // ADD 0x7FFF+1 wraps
    run_instr(16'hAA1F, 16'hEDCC, 1'b0);   // MUL 0x1234*-1
    run_instr(16'h6240, 16'h7FFE, 1'b0);   // SUB 0x7FFF-1
    run_instr(16'h4201, 16'h8000, 1'b0);   // ADDI 0x7FFF+1
    run_instr(16'h8C03, 16'hFFFF, 1'b0);   // SUBI 2-3
    run_instr(16'hEA00, 16'h1234, 1'b0);   // DISPLAY mem[5]
    run_instr(16'hC000, 16'h0000, 1'b0);   // CLEAR
    // send pulses during READ and SHOW must be ignored.
    run_instr(16'h2248, 16'h8000, 1'b1);

    // Power drop while READ waits forever.
    ack_en = 1'b0;
    wait_state(3'b001, 20, "pwr_fetch");
    bus.instr = 16'hAA1F;
    bus.send  = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    wait_state(3'b011, 5, "pwr_read");
    repeat (3) @(negedge clk);
    bus.power = 1'b0;
    @(negedge clk);
    check("pwr_off_state", {29'd0, bus.stateCPU}, 32'd0);
    check("pwr_off_dv", {31'd0, bus.disp_valid}, 32'd0);
    check("pwr_keep_result", {16'd0, bus.valorGuardarRAM}, 32'h8000);
    check("pwr_keep_disp", {16'd0, bus.disp_val}, 32'h8000);
    bus.power = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    check("pwr_up_fetch", {29'd0, bus.stateCPU}, 32'd1);
    $display("[TB] power drop in READ -> OFF -> FETCH");

    // Reset in the middle of SHOW discards the instruction.
    bus.instr = 16'h07FB;
    bus.send  = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    wait_state(3'b101, 10, "mid_show");
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_release", {29'd0, bus.stateCPU}, 32'd1);
    $display("[TB] reset during SHOW");

`ifdef CPU_CTRL_WDOG_EN
    begin
      int cyc;
      ack_en = 1'b0;
      bus.instr = 16'h2248;
      bus.send  = 1'b1;
      @(negedge clk);
      bus.send = 1'b0;
      wait_state(3'b011, 5, "wdog_read");
      cyc = 0;
      while (bus.stateCPU === 3'b011 && cyc < 40) begin
        cyc++;
        @(negedge clk);
      end
      check("wdog_cycles", cyc, WDOG_CYCLES);
      check("wdog_state", {29'd0, bus.stateCPU}, 32'd1);
      check("wdog_err", {31'd0, bus.err}, 32'd1);
      ack_en = 1'b1;
      run_instr(16'h07FB, 16'hFFFB, 1'b0);
      check("wdog_err_sticky", {31'd0, bus.err}, 32'd1);
      rst = 1'b1;
      #1;
      check("wdog_err_rst", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("[TB] watchdog timeout after %0d cycles", cyc);
    end
`else
    check("err_tied_low", {31'd0, bus.err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Top-level sequencer for the Mini-CPU, directly upstream of the RAM bank.
- Drives `stateCPU`, `opcode`, the three addresses and the write-back value into the RAM bank.
- Consumes the RAM bank's `v1RAM`/`v2RAM` read data and its `read`/`stored` handshake flags.
- Contains the instruction latch/decoder, the single-cycle ALU and the result/display register.

Parameters:
- SHOW_CYCLES, 4, number of clocks the SHOW state holds `disp_valid` high (minimum 1).
- WDOG_CYCLES, 15, handshake timeout in READ/STORE; used only when the watchdog is compiled in.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- power  input  1  level; 1 = CPU on, 0 = forces OFF.
- send  input  1  single-cycle pulse; accept `instr` (already debounced and edge-detected upstream).
- instr  input  16  instruction word, sampled only on `send` while in FETCH.
- v1RAM  input  16  RAM operand 1.
- v2RAM  input  16  RAM operand 2.
- read  input  1  RAM read-done flag.
- stored  input  1  RAM write-done flag.
- stateCPU  output  3  current state: OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, SHOW=101, STORE=110.
- opcode  output  3  latched `instr[15:13]`.
- addr1  output  4  latched `instr[12:9]`.
- addr2  output  4  latched `instr[8:5]`.
- addr3  output  4  latched `instr[4:1]`.
- valorGuardarRAM  output  16  ALU result, write-back value.
- disp_val  output  16  value to display.
- disp_valid  output  1  high throughout SHOW.
- err  output  1  sticky watchdog error; constant 0 when the watchdog is compiled out.

Behaviour:
- Reset (async, rst=1): stateCPU=OFF; opcode, addr1-3 = 0; valorGuardarRAM=0; disp_val=0; disp_valid=0; err=0; internal counters and instruction latch = 0.
- Opcodes: LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
- Immediates:
  - imm9 = sign-extended `instr[8:0]`; used by LOAD only.
  - imm5 = sign-extended `instr[4:0]`; used by ADDI/SUBI/MUL.
  - Both are latched together with `instr` in FETCH.
- power=0 in any state: next state is OFF and `disp_valid` clears. This takes priority over every other transition.
- OFF -> FETCH when power=1.
- FETCH:
  - Waits for `send`.
  - On send=1, latches `instr`; `opcode` and addr1-3 update on that same edge.
  - Next state is DECODE.
- DECODE: one cycle -> READ.
- READ:
  - Holds until read=1 is sampled; next state is CALC.
  - The RAM registers `read` one clock after entry, so minimum READ residency is 2 cycles.
- CALC: one cycle. Registers `valorGuardarRAM`, all 16-bit two's-complement, wrapping modulo 2^16:
  - LOAD: imm9.
  - ADD: v1+v2.
  - ADDI: v1+imm5.
  - SUB: v1-v2.
  - SUBI: v1-imm5.
  - MUL: low 16 bits of v1*imm5.
  - CLEAR: 0.
  - DISPLAY: v1.
  - Same edge: `disp_val` takes the identical value. Next state is SHOW.
- SHOW:
  - `disp_valid`=1 for exactly SHOW_CYCLES cycles, then -> STORE.
  - `disp_val` holds its value until the next CALC or reset.
- STORE:
  - Holds until stored=1 is sampled, then -> FETCH.
  - DISPLAY also passes through STORE; the RAM performs no write for it but still raises `stored`.
- `send` asserted outside FETCH is ignored and is not queued.
- `instr`, `opcode` and addr1-3 are stable from FETCH exit until the next accepted `send`.
- Reset mid-instruction: the instruction is discarded and the RAM contents are left unchanged by this block.
- Power drop mid-READ/STORE:
  - Goes to OFF; the instruction is abandoned.
  - On the next power-up, starts at FETCH.
  - `valorGuardarRAM` and `disp_val` retain their values.

Optional Feature:
- CPU_CTRL_WDOG_EN
- Defined:
  - A counter clears on entry to READ or STORE and increments each cycle while waiting.
  - If it reaches WDOG_CYCLES without the awaited flag, `err` is set (sticky until rst) and the next state is FETCH.
  - A timed-out READ skips CALC/SHOW/STORE, so no RAM write occurs.
- Undefined: no counter; READ/STORE wait indefinitely; `err` is tied to 0.

Test Plan:
- Reset while running; power=1 -> all outputs 0, stateCPU=000 during rst; first cycle after rst release goes to 001.
- FETCH with send + LOAD, addr1=3, imm9=-5 (instr=0x07FB); RAM model acks -> valorGuardarRAM=0xFFFB, disp_valid high 4 cycles, sequence 001,010,011,100,101,110,001.
- ADD addr1=1 (0x7FFF), addr2=2 (0x0001), addr3=4 -> result 0x8000 (wrap); MUL v1=0x1234, imm5=-1 -> 0xEDCC.
- send pulsed during READ and again during SHOW -> ignored; opcode/addrs unchanged; only the FETCH-time `send` is taken.
- power dropped during READ (read never asserted) -> OFF next cycle, disp_valid=0; power restored -> FETCH.
- CPU_CTRL_WDOG_EN defined, WDOG_CYCLES=15, read held 0 -> err=1 after 15 waiting cycles, state=FETCH, err stays 1 across later good instructions until rst.
